seeprom_rd_ctrl: RTL and testbench

//  SPI serial-EEPROM read sequencer for the MiniCPU instruction/data fetch path.
//  On request it asserts CSn, then shifts out the READ command and address MSB-first,

---
 rtl/seeprom_rd_ctrl_if.sv | 29 ++
 rtl/seeprom_rd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seeprom_rd_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seeprom_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seeprom_rd_ctrl_if
// Brief    : CPU-side handshake bundle of the SPI serial-EEPROM read sequencer.
//            master = bit-serial CPU fetch unit, slave = seeprom_rd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface seeprom_rd_ctrl_if #(
  parameter int ADDR_W = 16
) ();
  logic              req;   // start / restart a read at addr
  logic [ADDR_W-1:0] addr;  // start address, latched on accepted req
  logic              stop;  // terminate the stream
  logic              hold;  // CPU stall, no new data bits while high
  logic              busy;  // transaction in progress
  logic              rdy;   // one-cycle strobe: dout holds a new bit
  logic              dout;  // serial data bit towards the CPU

  modport master (
    output req, addr, stop, hold,
    input  busy, rdy, dout
  );

  modport slave (
    input  req, addr, stop, hold,
    output busy, rdy, dout
  );
endinterface
`default_nettype wire

// File: rtl/seeprom_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seeprom_rd_ctrl
// Brief    : SPI (mode 0) serial-EEPROM read sequencer. Selects the part,
//            shifts out READ opcode + address MSB-first, then streams MISO
//            bits to the CPU with one rdy strobe per bit. hold stalls SCK in
//            the data phase, req while busy jumps to a new address, stop ends
//            the stream.
// Revision : 1.0 - initial release
// ============================================================================
module seeprom_rd_ctrl #(
  parameter int         CLK_DIV  = 2,
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] RD_CMD   = 8'h03,
  parameter int         CS_SETUP = 1,
  parameter int         CS_DESEL = 4
) (
  input  logic             clk,
  input  logic             nrst,
  seeprom_rd_ctrl_if.slave cpu,
  output logic             csn,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_CNT_MAX = (CS_SETUP > CS_DESEL) ? CS_SETUP : CS_DESEL;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam int c_SHIFT_W = 8 + ADDR_W;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE    = c_DIV_W'(1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_DESEL_LAST = c_CNT_W'(CS_DESEL - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [4:0]         c_CMD_LAST   = 5'd7;
  localparam logic [4:0]         c_ADR_LAST   = 5'(ADDR_W - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_SETUP = 3'd1;
  localparam logic [2:0] c_S_CMD   = 3'd2;
  localparam logic [2:0] c_S_ADR   = 3'd3;
  localparam logic [2:0] c_S_DAT   = 3'd4;
  localparam logic [2:0] c_S_PAUSE = 3'd5;
  localparam logic [2:0] c_S_DESEL = 3'd6;

  logic [2:0]           r_state;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [4:0]           r_bit_cnt;
  logic [c_SHIFT_W-1:0] r_shift;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_restart;
  logic                 r_csn;
  logic                 r_sck;
  logic                 r_mosi;
  logic                 r_dout;
  logic                 r_rdy;
  logic                 r_busy;

  logic w_div_end;
  logic w_abort;
  logic w_restart;

  // End of an SCK half-period; the abort path covers every active state
  // except DESEL, where req only refreshes the pending address.
  assign w_div_end = (r_div_cnt == c_DIV_LAST);
  assign w_abort   = (r_state != c_S_IDLE) && (r_state != c_S_DESEL) &&
                     (cpu.req || cpu.stop);
  assign w_restart = cpu.req || (r_restart && !cpu.stop);

  assign csn      = r_csn;
  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign cpu.dout = r_dout;
  assign cpu.rdy  = r_rdy;
  assign cpu.busy = r_busy;

  // Sequencer: state, SCK divider, shift-out and MISO capture.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= c_S_IDLE;
      r_div_cnt <= '0;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_restart <= 1'b0;
      r_csn     <= 1'b1;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_dout    <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_abort) begin
        // Abandon the current bit/frame; req wins over stop.
        r_state   <= c_S_DESEL;
        r_csn     <= 1'b1;
        r_sck     <= 1'b0;
        r_mosi    <= 1'b0;
        r_cnt     <= '0;
        r_div_cnt <= '0;
        r_restart <= cpu.req;
        if (cpu.req) begin
          r_addr <= cpu.addr;
        end
      end else begin
        case (r_state)
          c_S_IDLE: begin
            if (cpu.req) begin
              r_addr  <= cpu.addr;
              r_busy  <= 1'b1;
              r_csn   <= 1'b0;
              r_cnt   <= '0;
              r_state <= c_S_SETUP;
            end
          end

          c_S_SETUP: begin
            if (r_cnt == c_SETUP_LAST) begin
              r_state   <= c_S_CMD;
              r_mosi    <= RD_CMD[7];
              r_shift   <= {RD_CMD[6:0], r_addr, 1'b0};
              r_div_cnt <= '0;
              r_sck     <= 1'b0;
              r_bit_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end

          c_S_CMD, c_S_ADR: begin
            if (w_div_end) begin
              r_div_cnt <= '0;
              r_sck     <= ~r_sck;
              if (r_sck) begin
                // Falling edge: present the next outgoing bit.
                r_mosi  <= r_shift[c_SHIFT_W-1];
                r_shift <= r_shift << 1;
                if (r_state == c_S_CMD && r_bit_cnt == c_CMD_LAST) begin
                  r_state   <= c_S_ADR;
                  r_bit_cnt <= '0;
                end else if (r_state == c_S_ADR && r_bit_cnt == c_ADR_LAST) begin
                  r_state   <= c_S_DAT;
                  r_mosi    <= 1'b0;
                  r_bit_cnt <= '0;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                end
              end
            end else begin
              r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end
          end

          c_S_DAT: begin
            if (w_div_end) begin
              r_div_cnt <= '0;
              if (!r_sck) begin
                if (cpu.hold) begin
                  r_state <= c_S_PAUSE;
                end else begin
                  r_sck  <= 1'b1;
                  r_dout <= miso;
                  r_rdy  <= 1'b1;
                end
              end else begin
                r_sck <= 1'b0;
              end
            end else begin
              r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end
          end

          c_S_PAUSE: begin
            // SCK parked low; the held bit is taken as soon as hold drops.
            if (!cpu.hold) begin
              r_state   <= c_S_DAT;
              r_div_cnt <= '0;
              r_sck     <= 1'b1;
              r_dout    <= miso;
              r_rdy     <= 1'b1;
            end
          end

          c_S_DESEL: begin
            if (cpu.req) begin
              r_addr <= cpu.addr;
            end
            if (r_cnt == c_DESEL_LAST) begin
              r_cnt     <= '0;
              r_restart <= 1'b0;
              if (w_restart) begin
                r_state <= c_S_SETUP;
                r_csn   <= 1'b0;
              end else begin
                r_state <= c_S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt     <= r_cnt + c_CNT_ONE;
              r_restart <= w_restart;
            end
          end

          default: begin
            r_state <= c_S_IDLE;
            r_csn   <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seeprom_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seeprom_rd_ctrl
// Brief    : Self-checking bench for seeprom_rd_ctrl with a behavioural SPI
//            EEPROM (decodes the frame, streams bytes with auto-increment).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seeprom_rd_ctrl;

  // Req sampled at edge N -> first rdy observed after edge N+LAT.
  localparam int LAT  = 1 + (8 + 16) * 2 * 2 + 2;
  localparam int PER  = 4;

  logic clk = 1'b0;
  logic nrst;
  logic csn, sck, mosi;
  logic miso = 1'b0;

  seeprom_rd_ctrl_if #(.ADDR_W(16)) cpu_if ();

  seeprom_rd_ctrl dut (
    .clk  (clk),
    .nrst (nrst),
    .cpu  (cpu_if),
    .csn  (csn),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard state
  logic [15:0] exp_addr = '0;
  int          rx_cnt = 0;
  logic [7:0]  rx_shift = '0;
  logic        rdy_ok = 1'b0;
  int          last_rdy = 0;
  logic        have_last = 1'b0;

  logic [23:0] frame_q[$];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  function automatic logic stream_bit(input logic [15:0] a, input int n);
    logic [7:0] b;
    b = mem_byte(a + 16'(n / 8));
    return b[7 - (n % 8)];
  endfunction

  // Behavioural EEPROM: sample MOSI on SCK rise, drive MISO after SCK fall.
  int          ee_bits = 0;
  int          ee_dcnt = 0;
  logic [23:0] ee_frame = '0;
  logic [15:0] ee_addr = '0;
  logic        ee_prev_sck = 1'b0;
  always @(posedge clk) begin
    #1;
    if (csn !== 1'b0) begin
      ee_bits = 0;
      ee_dcnt = 0;
      miso    = 1'b0;
    end else if (sck && !ee_prev_sck) begin
      if (ee_bits < 24) begin
        ee_frame = {ee_frame[22:0], mosi};
        ee_bits++;
        if (ee_bits == 24) begin
          frame_q.push_back(ee_frame);
          ee_addr = ee_frame[15:0];
        end
      end else begin
        ee_dcnt++;
      end
    end else if (!sck && ee_prev_sck && ee_bits == 24) begin
      miso = stream_bit(ee_addr, ee_dcnt);
    end
    ee_prev_sck = sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; every rdy strobe is scored against the memory model.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (cpu_if.rdy === 1'b1) begin
      check("rdy_allowed", {31'd0, rdy_ok}, 32'd1);
      check("dout", {31'd0, cpu_if.dout}, {31'd0, stream_bit(exp_addr, rx_cnt)});
      if (have_last) check("rdy_spacing", {31'd0, (cyc - last_rdy) >= PER}, 32'd1);
      last_rdy  = cyc;
      have_last = 1'b1;
      rx_shift  = {rx_shift[6:0], cpu_if.dout};
      rx_cnt++;
    end
  endtask

  task automatic wait_rdy(input string tag, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_if.rdy !== 1'b1 && n < bound);
    if (cpu_if.rdy !== 1'b1) begin
      check(tag, {31'd0, cpu_if.rdy}, 32'd1);
      n = -1;
    end
  endtask

  task automatic recv_bits(input int n);
    int k;
    for (int i = 0; i < n; i++) wait_rdy("recv_timeout", 20, k);
  endtask

  // t0: cycle in which csn was first seen low for this frame.
  task automatic expect_frame(input logic [15:0] a, input int t0);
    int k;
    exp_addr = a;
    rx_cnt   = 0;
    rdy_ok   = 1'b1;
    wait_rdy("first_rdy_timeout", LAT + 20, k);
    check("first_rdy_latency", cyc - t0, LAT);
    check("frame_seen", frame_q.size(), 1);
    if (frame_q.size() > 0) check("mosi_frame", {8'd0, frame_q.pop_front()}, {8'd0, 8'h03, a});
  endtask

  task automatic start_read(input logic [15:0] a);
    cpu_if.req  = 1'b1;
    cpu_if.addr = a;
    tick();
    cpu_if.req  = 1'b0;
    check("start_csn", {31'd0, csn}, 32'd0);
    check("start_busy", {31'd0, cpu_if.busy}, 32'd1);
    expect_frame(a, cyc);
  endtask

  // Issue req (with optional stop) mid-bit-5 and follow the restarted frame.
  task automatic jump(input logic [15:0] a, input logic with_stop, input string tag);
    int k;
    int n;
    while ((rx_cnt % 8) != 5) wait_rdy("jump_align_timeout", 20, k);
    tick();
    tick();
    rdy_ok      = 1'b0;
    cpu_if.req  = 1'b1;
    cpu_if.stop = with_stop;
    cpu_if.addr = a;
    tick();
    cpu_if.req  = 1'b0;
    cpu_if.stop = 1'b0;
    n = (csn === 1'b1) ? 1 : 0;
    while (csn === 1'b1 && n < 20) begin
      check({tag, "_busy"}, {31'd0, cpu_if.busy}, 32'd1);
      tick();
      if (csn === 1'b1) n++;
    end
    check({tag, "_csn_high_cycles"}, n, 4);
    expect_frame(a, cyc);
  endtask

  initial begin
    int k;
    int n;
    logic [15:0] a;
    nrst        = 1'b0;
    cpu_if.req  = 1'b1;
    cpu_if.addr = 16'hBEEF;
    cpu_if.stop = 1'b0;
    cpu_if.hold = 1'b0;

    // Reset held 3 cycles with req asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_csn", {31'd0, csn}, 32'd1);
      check("rst_sck", {31'd0, sck}, 32'd0);
      check("rst_mosi", {31'd0, mosi}, 32'd0);
      check("rst_rdy", {31'd0, cpu_if.rdy}, 32'd0);
      check("rst_busy", {31'd0, cpu_if.busy}, 32'd0);
    end
    nrst       = 1'b1;
    cpu_if.req = 1'b0;
    tick();
    tick();
    check("idle_busy", {31'd0, cpu_if.busy}, 32'd0);
    check("idle_csn", {31'd0, csn}, 32'd1);

    // Basic read at 0x1234: first byte must be 0xA5
    start_read(16'h1234);
    recv_bits(7);
    check("byte0_A5", {24'd0, rx_shift}, 32'h0000_00A5);
    recv_bits(3);

    // Deterministic hold right after a bit strobe
    wait_rdy("hold_align_timeout", 20, k);
    cpu_if.hold = 1'b1;
    rdy_ok      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_csn", {31'd0, csn}, 32'd0);
      if (i >= 1) check("hold_sck", {31'd0, sck}, 32'd0);
    end
    cpu_if.hold = 1'b0;
    rdy_ok      = 1'b1;
    wait_rdy("hold_resume_timeout", 10, n);
    check("hold_resume_fast", {31'd0, (n >= 1 && n <= 3)}, 32'd1);
    recv_bits(12);

    // Jump to 0x0100 during data bit 5
    jump(16'h0100, 1'b0, "jump");
    recv_bits(10);

    // Stop during data
    tick();
    rdy_ok      = 1'b0;
    cpu_if.stop = 1'b1;
    tick();
    cpu_if.stop = 1'b0;
    check("stop_csn", {31'd0, csn}, 32'd1);
    n = 0;
    while (cpu_if.busy === 1'b1 && n < 20) begin
      tick();
      n++;
      check("stop_csn_held", {31'd0, csn}, 32'd1);
    end
    check("stop_busy_cycles", n, 4);
    for (int i = 0; i < 6; i++) tick();
    check("stop_idle_csn", {31'd0, csn}, 32'd1);

    // Stop in IDLE has no effect
    cpu_if.stop = 1'b1;
    tick();
    cpu_if.stop = 1'b0;
    tick();
    check("stop_idle_busy", {31'd0, cpu_if.busy}, 32'd0);

    // Stop + Req together restarts
    start_read(16'h4321);
    recv_bits(3);
    jump(16'hA0F0, 1'b1, "stopreq");
    recv_bits(9);

    // Reset in the address phase
    cpu_if.stop = 1'b1;
    tick();
    cpu_if.stop = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rdy_ok      = 1'b0;
    cpu_if.req  = 1'b1;
    cpu_if.addr = 16'h5A5A;
    tick();
    cpu_if.req  = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    nrst = 1'b0;
    tick();
    check("mrst_csn", {31'd0, csn}, 32'd1);
    check("mrst_sck", {31'd0, sck}, 32'd0);
    check("mrst_mosi", {31'd0, mosi}, 32'd0);
    check("mrst_rdy", {31'd0, cpu_if.rdy}, 32'd0);
    check("mrst_busy", {31'd0, cpu_if.busy}, 32'd0);
    check("mrst_dout", {31'd0, cpu_if.dout}, 32'd0);
    nrst = 1'b1;
    tick();
    check("mrst_no_frame", frame_q.size(), 0);
    a = 16'($urandom);
    start_read(a);
    recv_bits(15);

    // Randomised reads with random holds
    for (int r = 0; r < 3; r++) begin
      cpu_if.stop = 1'b1;
      tick();
      cpu_if.stop = 1'b0;
      rdy_ok      = 1'b0;
      n = 0;
      while (cpu_if.busy === 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check("rand_idle", {31'd0, cpu_if.busy}, 32'd0);
      a = 16'($urandom);
      start_read(a);
      for (int j = 0; j < 10; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          cpu_if.hold = 1'b1;
          rdy_ok      = 1'b0;
          n = int'($urandom_range(1, 12));
          for (int h = 0; h < n; h++) tick();
          cpu_if.hold = 1'b0;
          rdy_ok      = 1'b1;
        end
        recv_bits(int'($urandom_range(1, 5)));
      end
      check("rand_stream_len", {31'd0, rx_cnt >= 11}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
